// File: rtl/adder_2_seq_arb_if.sv
// Request, response and adder-slice signals of the serial add arbiter.
interface adder_2_seq_arb_if #(parameter int WIDTH = 8);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_cin;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_cin;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_sum;
  logic             rsp_cout;
  logic [1:0]       slice_a;
  logic [1:0]       slice_b;
  logic             slice_cin;
  logic [1:0]       slice_sum;
  logic             slice_cout;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cin,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_cin,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_sum, rsp_cout,
    input  rsp_ready,
    output slice_a, slice_b, slice_cin,
    input  slice_sum, slice_cout
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_cin,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_cin,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_sum, rsp_cout,
    output rsp_ready,
    input  slice_a, slice_b, slice_cin,
    output slice_sum, slice_cout
  );
endinterface

// File: rtl/adder_2_seq_arb.sv
// Round-robin shares one external 2-bit adder slice between two requesters; result valid WIDTH/2 edges after accept.
// Requests are refused while an operation runs or its result waits; the result holds until rsp_ready.
module adder_2_seq_arb #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  adder_2_seq_arb_if.slave bus
);
  localparam int STEPS = WIDTH / 2;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic             last;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             id_r;
  logic             valid_r;
  logic             gnt0;
  logic             gnt1;

  // On a tie the requester that was not served last wins.
  assign gnt0 = bus.req0_valid && (!bus.req1_valid || last);
  assign gnt1 = bus.req1_valid && (!bus.req0_valid || !last);

  assign bus.req0_ready = !rst && (state == IDLE) && gnt0;
  assign bus.req1_ready = !rst && (state == IDLE) && gnt1;

  assign bus.slice_a   = (state == RUN) ? a_sh[1:0] : 2'b00;
  assign bus.slice_b   = (state == RUN) ? b_sh[1:0] : 2'b00;
  assign bus.slice_cin = (state == RUN) ? carry : 1'b0;

  assign bus.rsp_valid = valid_r;
  assign bus.rsp_id    = id_r;
  assign bus.rsp_sum   = sum_r;
  assign bus.rsp_cout  = cout_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      last    <= 1'b1;
      a_sh    <= '0;
      b_sh    <= '0;
      carry   <= 1'b0;
      count   <= '0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      id_r    <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt0 || gnt1) begin
            a_sh  <= gnt1 ? bus.req1_a : bus.req0_a;
            b_sh  <= gnt1 ? bus.req1_b : bus.req0_b;
            carry <= gnt1 ? bus.req1_cin : bus.req0_cin;
            count <= '0;
            id_r  <= gnt1;
            last  <= gnt1;
            state <= RUN;
          end
        end
        RUN: begin
          // Result pairs enter at the top; after STEPS shifts the first pair sits at bit 0.
          sum_r <= (sum_r >> 2) | (WIDTH'(bus.slice_sum) << (WIDTH - 2));
          carry <= bus.slice_cout;
          a_sh  <= a_sh >> 2;
          b_sh  <= b_sh >> 2;
          count <= count + CW'(1);
          if (count == CW'(STEPS - 1)) begin
            cout_r  <= bus.slice_cout;
            valid_r <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            valid_r <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_2_seq_arb.sv
// Bench for adder_2_seq_arb: per-cycle reference model on a WIDTH=8 instance plus directed vectors,
// and an exhaustive sweep of a WIDTH=2 instance.
module tb_adder_2_seq_arb;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  int   nvec = 0;
  int   nbad = 0;

  always #5 clk = ~clk;

  adder_2_seq_arb_if #(.WIDTH(W)) i8 ();
  adder_2_seq_arb_if #(.WIDTH(2)) i2 ();

  adder_2_seq_arb #(.WIDTH(W)) u8 (.clk(clk), .rst(rst), .bus(i8));
  adder_2_seq_arb #(.WIDTH(2)) u2 (.clk(clk), .rst(rst), .bus(i2));

  // The external adder slices.
  assign {i8.slice_cout, i8.slice_sum} = i8.slice_a + i8.slice_b + i8.slice_cin;
  assign {i2.slice_cout, i2.slice_sum} = i2.slice_a + i2.slice_b + i2.slice_cin;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: 0 idle, 1 running (m_k pairs done), 2 result waiting.
  int               m_st = 0;
  int               m_k = 0;
  bit               m_last = 1'b1;
  bit               m_id = 1'b0;
  logic [W-1:0]     m_a = '0;
  logic [W-1:0]     m_b = '0;
  bit               m_cin = 1'b0;

  always @(negedge clk) begin
    int full, msk, sa, sb, sc;
    bit g0, g1;
    if (rst) begin
      chk("m_rst_valid", i8.rsp_valid, 0);
      chk("m_rst_sum", {i8.rsp_cout, i8.rsp_id, i8.rsp_sum}, 0);
      chk("m_rst_ready", {i8.req0_ready, i8.req1_ready}, 0);
      chk("m_rst_slice", {i8.slice_a, i8.slice_b, i8.slice_cin}, 0);
      m_st   = 0;
      m_last = 1'b1;
    end else begin
      g0 = i8.req0_valid && (!i8.req1_valid || m_last);
      g1 = i8.req1_valid && (!i8.req0_valid || !m_last);
      chk("m_req0_ready", i8.req0_ready, (m_st == 0) && g0);
      chk("m_req1_ready", i8.req1_ready, (m_st == 0) && g1);
      chk("m_rsp_valid", i8.rsp_valid, m_st == 2);
      if (m_st == 2) begin
        full = int'(m_a) + int'(m_b) + int'(m_cin);
        chk("m_rsp_sum", i8.rsp_sum, full & 255);
        chk("m_rsp_cout", i8.rsp_cout, full >> 8);
        chk("m_rsp_id", i8.rsp_id, m_id);
      end
      if (m_st == 1) begin
        msk = (1 << (2 * m_k)) - 1;
        sa  = (int'(m_a) >> (2 * m_k)) & 3;
        sb  = (int'(m_b) >> (2 * m_k)) & 3;
        sc  = (((int'(m_a) & msk) + (int'(m_b) & msk) + int'(m_cin)) >> (2 * m_k)) & 1;
        chk("m_slice", {i8.slice_a, i8.slice_b, i8.slice_cin}, {sa[1:0], sb[1:0], sc[0]});
      end else begin
        chk("m_slice_idle", {i8.slice_a, i8.slice_b, i8.slice_cin}, 0);
      end
      case (m_st)
        0: if (g0 || g1) begin
          m_st   = 1;
          m_k    = 0;
          m_id   = g1;
          m_last = g1;
          m_a    = g1 ? i8.req1_a : i8.req0_a;
          m_b    = g1 ? i8.req1_b : i8.req0_b;
          m_cin  = g1 ? i8.req1_cin : i8.req0_cin;
        end
        1: begin
          m_k++;
          if (m_k == W / 2) m_st = 2;
        end
        default: if (i8.rsp_ready) m_st = 0;
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input bit id);
    bit ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      ok = id ? i8.req1_ready : i8.req0_ready;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    step();
  endtask

  task automatic wait_rsp(output int lat);
    lat = -1;
    for (int k = 1; k <= 30 && lat < 0; k++) begin
      @(negedge clk);
      if (i8.rsp_valid) lat = k - 1;
    end
    if (lat < 0) chk("rsp_timeout", 0, 1);
  endtask

  task automatic drive(input bit id, input logic [W-1:0] a, input logic [W-1:0] b, input bit cin);
    if (id) begin
      i8.req1_valid = 1'b1; i8.req1_a = a; i8.req1_b = b; i8.req1_cin = cin;
    end else begin
      i8.req0_valid = 1'b1; i8.req0_a = a; i8.req0_b = b; i8.req0_cin = cin;
    end
  endtask

  task automatic scramble();
    i8.req0_valid = 1'b0; i8.req1_valid = 1'b0;
    i8.req0_a = W'($urandom); i8.req0_b = W'($urandom); i8.req0_cin = 1'($urandom);
    i8.req1_a = W'($urandom); i8.req1_b = W'($urandom); i8.req1_cin = 1'($urandom);
  endtask

  task automatic single(input bit id, input logic [W-1:0] a, input logic [W-1:0] b, input bit cin,
                        input logic [W-1:0] es, input bit ec, input string nm);
    int lat;
    drive(id, a, b, cin);
    wait_accept(id);
    scramble();
    wait_rsp(lat);
    chk({nm, "_latency"}, lat, 4);
    chk({nm, "_sum"}, i8.rsp_sum, es);
    chk({nm, "_cout"}, i8.rsp_cout, ec);
    chk({nm, "_id"}, i8.rsp_id, id);
    step();
  endtask

  initial begin
    int lat;
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst = 1'b1;
    i8.req0_valid = 0; i8.req0_a = 0; i8.req0_b = 0; i8.req0_cin = 0;
    i8.req1_valid = 0; i8.req1_a = 0; i8.req1_b = 0; i8.req1_cin = 0;
    i8.rsp_ready = 1'b1;
    i2.req0_valid = 0; i2.req0_a = 0; i2.req0_b = 0; i2.req0_cin = 0;
    i2.req1_valid = 0; i2.req1_a = 0; i2.req1_b = 0; i2.req1_cin = 0;
    i2.rsp_ready = 1'b1;
    #2;
    chk("reset_valid", i8.rsp_valid, 0);
    chk("reset_outputs", {i8.rsp_cout, i8.rsp_id, i8.rsp_sum, i8.slice_a, i8.slice_b, i8.slice_cin}, 0);
    step();
    step();
    rst = 1'b0;
    step();

    // Single operations with hand-computed results.
    single(1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ff_plus_01");
    single(1'b1, 8'h7F, 8'h80, 1'b1, 8'h00, 1'b1, "7f_plus_80_c");
    single(1'b0, 8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, "55_plus_aa");
    single(1'b1, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "ff_plus_ff_c");

    // Both requesters held valid from reset: grants alternate starting with req0.
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1'b0, 8'h10, 8'h20, 1'b0);
    drive(1'b1, 8'h03, 8'h04, 1'b1);
    for (int r = 0; r < 4; r++) begin
      wait_rsp(lat);
      chk("rr_order", i8.rsp_id, r % 2);
      chk("rr_sum", i8.rsp_sum, (r % 2) ? 8'h08 : 8'h30);
    end
    step();
    scramble();
    step();

    // Backpressure: result must hold while the consumer stalls.
    i8.rsp_ready = 1'b0;
    drive(1'b0, 8'h12, 8'h34, 1'b0);
    wait_accept(1'b0);
    scramble();
    i8.req1_valid = 1'b1;
    wait_rsp(lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", i8.rsp_valid, 1);
      chk("bp_result", {i8.rsp_cout, i8.rsp_id, i8.rsp_sum}, {1'b0, 1'b0, 8'h46});
      chk("bp_ready", {i8.req0_ready, i8.req1_ready}, 0);
      chk("bp_slice", {i8.slice_a, i8.slice_b, i8.slice_cin}, 0);
    end
    step();
    i8.rsp_ready = 1'b1;
    i8.req1_valid = 1'b0;
    @(negedge clk);
    chk("bp_xfer_valid", i8.rsp_valid, 1);
    @(negedge clk);
    chk("bp_after_xfer", i8.rsp_valid, 0);
    step();

    // Reset during the second RUN cycle.
    drive(1'b0, 8'hFF, 8'h01, 1'b0);
    wait_accept(1'b0);
    step();
    chk("run2_slice_a", i8.slice_a, 2'b11);
    rst = 1'b1;
    i8.req1_valid = 1'b1; i8.req1_a = 8'h01; i8.req1_b = 8'h02; i8.req1_cin = 1'b0;
    #1;
    chk("run_rst_slice", {i8.slice_a, i8.slice_b, i8.slice_cin}, 0);
    chk("run_rst_valid", i8.rsp_valid, 0);
    step();
    rst = 1'b0;
    wait_rsp(lat);
    chk("post_rst_id", i8.rsp_id, 0);
    chk("post_rst_sum", {i8.rsp_cout, i8.rsp_sum}, 9'h100);
    step();
    scramble();
    step();

    // Reset while a result waits in DONE.
    i8.rsp_ready = 1'b0;
    drive(1'b1, 8'h55, 8'hAA, 1'b0);
    wait_accept(1'b1);
    scramble();
    wait_rsp(lat);
    step();
    rst = 1'b1;
    #1;
    chk("done_rst_valid", i8.rsp_valid, 0);
    chk("done_rst_sum", i8.rsp_sum, 0);
    step();
    rst = 1'b0;
    i8.rsp_ready = 1'b1;
    step();
    step();
    chk("done_rst_no_rsp", i8.rsp_valid, 0);

    // WIDTH=2 instance: every operand combination, one-edge latency.
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        for (int c = 0; c < 2; c++) begin
          bit ok = 1'b0;
          i2.req0_valid = 1'b1; i2.req0_a = 2'(a); i2.req0_b = 2'(b); i2.req0_cin = 1'(c);
          for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            ok = i2.req0_ready;
          end
          if (!ok) chk("w2_accept_timeout", 0, 1);
          step();
          i2.req0_valid = 1'b0;
          @(negedge clk);
          chk("w2_valid_early", i2.rsp_valid, 0);
          @(negedge clk);
          chk("w2_valid", i2.rsp_valid, 1);
          chk("w2_result", {i2.rsp_cout, i2.rsp_sum}, a + b + c);
          step();
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
